// File: rtl/band_gain_mixer.sv
`default_nettype none
// ============================================================================
// band_gain_mixer : weights three band samples by decoded gain codes and sums
//                   them through one shared multiplier.   Revision: 1.0
// ============================================================================
module band_gain_mixer #(
  parameter int DATA_WD   = 24,
  parameter int GAIN_FRAC = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [2:0]                sel_gain_i [2:0],
  input  logic                      sample_valid_i,
  input  logic signed [DATA_WD-1:0] band0_i,
  input  logic signed [DATA_WD-1:0] band1_i,
  input  logic signed [DATA_WD-1:0] band2_i,
  output logic                      ready_o,
  output logic signed [DATA_WD-1:0] sample_o,
  output logic                      sample_valid_o,
  output logic                      sat_o,
  output logic                      overrun_o
);

  localparam int c_PROD_WD = DATA_WD + 7;
  localparam int c_ACC_WD  = DATA_WD + 9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    OUT  = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic signed [DATA_WD-1:0]  band_q [3];
  logic [2:0]                 code_q [3];
  logic signed [c_ACC_WD-1:0] acc_q, acc_d;
  logic signed [DATA_WD-1:0]  sample_q, sample_d;
  logic                       valid_q;
  logic                       sat_q, sat_d;
  logic                       overrun_q;

  logic                       w_load;
  logic                       w_mac_en;
  logic                       w_out_en;
  logic [1:0]                 w_mac_sel;
  logic signed [DATA_WD-1:0]  w_band;
  logic [2:0]                 w_code;
  logic [5:0]                 w_gain;
  logic signed [c_PROD_WD-1:0] w_band_ext;
  logic signed [c_PROD_WD-1:0] w_gain_ext;
  logic signed [c_PROD_WD-1:0] w_prod;
  logic signed [c_ACC_WD-1:0] w_shift;
  logic                       w_fits;

  always_comb begin
    state_d   = state_q;
    w_load    = 1'b0;
    w_mac_en  = 1'b0;
    w_out_en  = 1'b0;
    w_mac_sel = 2'd0;
    case (state_q)
      IDLE: begin
        if (sample_valid_i) begin
          w_load  = 1'b1;
          state_d = MAC0;
        end
      end
      MAC0: begin
        w_mac_en  = 1'b1;
        w_mac_sel = 2'd0;
        state_d   = MAC1;
      end
      MAC1: begin
        w_mac_en  = 1'b1;
        w_mac_sel = 2'd1;
        state_d   = MAC2;
      end
      MAC2: begin
        w_mac_en  = 1'b1;
        w_mac_sel = 2'd2;
        state_d   = OUT;
      end
      OUT: begin
        w_out_en = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand select for the single shared multiplier.
  always_comb begin
    w_band = band_q[0];
    w_code = code_q[0];
    case (w_mac_sel)
      2'd1: begin
        w_band = band_q[1];
        w_code = code_q[1];
      end
      2'd2: begin
        w_band = band_q[2];
        w_code = code_q[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (w_code)
      3'd0:    w_gain = 6'd0;
      3'd1:    w_gain = 6'd4;
      3'd2:    w_gain = 6'd8;
      3'd3:    w_gain = 6'd16;
      3'd4:    w_gain = 6'd24;
      3'd5:    w_gain = 6'd32;
      default: w_gain = 6'd16;
    endcase
  end

  assign w_band_ext = {{7{w_band[DATA_WD-1]}}, w_band};
  assign w_gain_ext = {{(c_PROD_WD-6){1'b0}}, w_gain};
  assign w_prod     = w_band_ext * w_gain_ext;

  always_comb begin
    acc_d = acc_q;
    if (w_load) begin
      acc_d = '0;
    end else if (w_mac_en) begin
      acc_d = acc_q + {{2{w_prod[c_PROD_WD-1]}}, w_prod};
    end
  end

  // Result fits when every bit above the output sign bit matches it.
  assign w_shift = acc_q >>> GAIN_FRAC;
  assign w_fits  = (&w_shift[c_ACC_WD-1:DATA_WD-1]) | ~(|w_shift[c_ACC_WD-1:DATA_WD-1]);

  always_comb begin
    sample_d = w_shift[DATA_WD-1:0];
    sat_d    = 1'b0;
    if (!w_fits) begin
      sat_d = 1'b1;
      if (w_shift[c_ACC_WD-1]) begin
        sample_d = {1'b1, {(DATA_WD-1){1'b0}}};
      end else begin
        sample_d = {1'b0, {(DATA_WD-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        band_q[k] <= '0;
        code_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      valid_q <= w_out_en;
      sat_q   <= w_out_en & sat_d;
      if (w_out_en) begin
        sample_q <= sample_d;
      end
      if (w_load) begin
        band_q[0] <= band0_i;
        band_q[1] <= band1_i;
        band_q[2] <= band2_i;
        code_q[0] <= sel_gain_i[0];
        code_q[1] <= sel_gain_i[1];
        code_q[2] <= sel_gain_i[2];
      end
      if (sample_valid_i && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign ready_o        = (state_q == IDLE);
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign sat_o          = sat_q;
  assign overrun_o      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_band_gain_mixer.sv
`default_nettype none
// ============================================================================
// tb_band_gain_mixer : directed and randomized checks of band_gain_mixer
//                      against a cycle-level transaction model. Revision: 1.0
// ============================================================================
module tb_band_gain_mixer;

  logic               clk;
  logic               rst_n;
  logic [2:0]         sel_gain [2:0];
  logic               valid_in;
  logic signed [23:0] b0, b1, b2;
  logic               ready_o;
  logic signed [23:0] sample_o;
  logic               sample_valid_o;
  logic               sat_o;
  logic               overrun_o;

  int n_cmp  = 0;
  int n_fail = 0;

  band_gain_mixer #(.DATA_WD(24), .GAIN_FRAC(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sel_gain_i     (sel_gain),
    .sample_valid_i (valid_in),
    .band0_i        (b0),
    .band1_i        (b1),
    .band2_i        (b2),
    .ready_o        (ready_o),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sat_o          (sat_o),
    .overrun_o      (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: a result appears 4 edges after acceptance, and
  // nothing new is accepted until then.
  int                 gtab [8] = '{0, 4, 8, 16, 24, 32, 16, 16};
  int                 busy;
  logic signed [23:0] pend_sample, exp_sample;
  logic               pend_sat, exp_sat, exp_valid, exp_over, exp_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; exp_sample = '0; exp_sat = 0; exp_valid = 0; exp_over = 0; exp_ready = 1;
      pend_sample = '0; pend_sat = 0;
    end else begin
      longint acc, res;
      exp_valid = 0;
      exp_sat   = 0;
      if (busy > 0) begin
        if (valid_in) exp_over = 1;
        busy = busy - 1;
        if (busy == 0) begin
          exp_valid  = 1;
          exp_sample = pend_sample;
          exp_sat    = pend_sat;
        end
      end else if (valid_in) begin
        acc = longint'(b0) * gtab[sel_gain[0]] + longint'(b1) * gtab[sel_gain[1]]
            + longint'(b2) * gtab[sel_gain[2]];
        res = acc >>> 4;
        pend_sat = 1;
        if (res > 64'sd8388607)       res = 64'sd8388607;
        else if (res < -64'sd8388608) res = -64'sd8388608;
        else                          pend_sat = 0;
        pend_sample = 24'(res);
        busy = 4;
      end
      exp_ready = (busy == 0);
    end
  end

  function automatic logic signed [23:0] rnd_band();
    case ($urandom_range(0, 3))
      0:       return 24'sh7FFFFF;
      1:       return -24'sh800000;
      default: return 24'($urandom);
    endcase
  endfunction

  // Drives one sample from idle and reports what the DUT produced; no checking.
  task automatic run_one(input logic [2:0] g0, g1, g2,
                         input logic signed [23:0] a0, a1, a2,
                         input logic [2:0] ng,
                         output logic signed [23:0] s, output logic sat,
                         output int lat, output bit rdy_ok);
    rdy_ok = 1; lat = -1; s = '0; sat = 0;
    @(posedge clk); #1;
    sel_gain[0] = g0; sel_gain[1] = g1; sel_gain[2] = g2;
    b0 = a0; b1 = a1; b2 = a2; valid_in = 1;
    @(posedge clk); #1;
    valid_in = 0;
    sel_gain[0] = ng; sel_gain[1] = ng; sel_gain[2] = ng;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(negedge clk);
      if (sample_valid_o) begin
        lat = i; s = sample_o; sat = sat_o;
        if (!ready_o) rdy_ok = 0;
      end else if (ready_o) begin
        rdy_ok = 0;
      end
    end
  endtask

  task automatic test_reset();
    logic signed [23:0] s; logic sat; int lat; bit rok; bit seen;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sample_o !== 24'sd0 || sample_valid_o !== 1'b0 || sat_o !== 1'b0 || overrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got s=%0d v=%b sat=%b ov=%b, want 0 0 0 0", sample_o, sample_valid_o, sat_o, overrun_o);
    end
    n_cmp++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    rst_n = 1;
    run_one(3'd3, 3'd3, 3'd3, 24'sd1000, 24'sd2000, -24'sd500, 3'd3, s, sat, lat, rok);
    @(posedge clk); #1;
    valid_in = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid_in = 0;
    #2;
    n_cmp++;
    if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL reset_pre_overrun: got %b want 1", overrun_o); end
    rst_n = 0;
    #1;
    n_cmp++;
    if (sample_o !== 24'sd0 || sample_valid_o !== 1'b0 || overrun_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midstream: got s=%0d v=%b ov=%b rdy=%b, want 0 0 0 1", sample_o, sample_valid_o, overrun_o, ready_o);
    end
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (sample_valid_o) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discard: got valid_seen=%b rdy=%b, want 0 1", seen, ready_o);
    end
  endtask

  task automatic test_unity();
    logic signed [23:0] s; logic sat; int lat; bit rok;
    run_one(3'd3, 3'd3, 3'd3, 24'sd1000, 24'sd2000, -24'sd500, 3'd3, s, sat, lat, rok);
    n_cmp++;
    if (s !== 24'sd2500 || sat !== 1'b0) begin n_fail++; $display("FAIL unity_value: got %0d sat=%b want 2500 sat=0", s, sat); end
    n_cmp++;
    if (lat !== 5 || rok !== 1'b1) begin n_fail++; $display("FAIL unity_timing: got lat=%0d rdy_ok=%b want 5 1", lat, rok); end
    @(negedge clk);
    n_cmp++;
    if (sample_valid_o !== 1'b0 || sample_o !== 24'sd2500) begin
      n_fail++; $display("FAIL unity_pulse_hold: got v=%b s=%0d want 0 2500", sample_valid_o, sample_o);
    end
  endtask

  task automatic test_mixed();
    logic signed [23:0] s; logic sat; int lat; bit rok;
    run_one(3'd0, 3'd5, 3'd1, 24'sd100, 24'sd100, 24'sd100, 3'd3, s, sat, lat, rok);
    n_cmp++;
    if (s !== 24'sd225 || sat !== 1'b0 || lat !== 5) begin n_fail++; $display("FAIL mixed_051: got %0d sat=%b lat=%0d want 225 0 5", s, sat, lat); end
    run_one(3'd7, 3'd6, 3'd2, 24'sd100, 24'sd100, 24'sd100, 3'd3, s, sat, lat, rok);
    n_cmp++;
    if (s !== 24'sd250 || sat !== 1'b0 || lat !== 5) begin n_fail++; $display("FAIL mixed_762: got %0d sat=%b lat=%0d want 250 0 5", s, sat, lat); end
  endtask

  task automatic test_floor_sat();
    logic signed [23:0] s; logic sat; int lat; bit rok;
    run_one(3'd1, 3'd0, 3'd0, -24'sd1, 24'sd0, 24'sd0, 3'd3, s, sat, lat, rok);
    n_cmp++;
    if (s !== -24'sd1 || sat !== 1'b0) begin n_fail++; $display("FAIL floor_neg: got %0d sat=%b want -1 0", s, sat); end
    run_one(3'd5, 3'd5, 3'd5, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 3'd3, s, sat, lat, rok);
    n_cmp++;
    if (s !== 24'sh7FFFFF || sat !== 1'b1) begin n_fail++; $display("FAIL sat_pos: got %h sat=%b want 7fffff 1", s, sat); end
    run_one(3'd5, 3'd5, 3'd5, -24'sh800000, -24'sh800000, -24'sh800000, 3'd3, s, sat, lat, rok);
    n_cmp++;
    if (s !== 24'sh800000 || sat !== 1'b1) begin n_fail++; $display("FAIL sat_neg: got %h sat=%b want 800000 1", s, sat); end
  endtask

  task automatic test_gain_change();
    logic signed [23:0] s; logic sat; int lat; bit rok;
    run_one(3'd3, 3'd3, 3'd3, 24'sd1000, 24'sd2000, -24'sd500, 3'd0, s, sat, lat, rok);
    n_cmp++;
    if (s !== 24'sd2500) begin n_fail++; $display("FAIL gain_inflight: got %0d want 2500", s); end
    run_one(3'd0, 3'd0, 3'd0, 24'sd1000, 24'sd2000, -24'sd500, 3'd0, s, sat, lat, rok);
    n_cmp++;
    if (s !== 24'sd0 || lat !== 5) begin n_fail++; $display("FAIL gain_next: got %0d lat=%0d want 0 5", s, lat); end
  endtask

  // Cycle-by-cycle comparison against the model; hold=1 keeps valid asserted.
  task automatic test_stream(input string name, input bit hold, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      valid_in = hold ? 1'b1 : ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 3; k++) sel_gain[k] = 3'($urandom_range(0, 7));
      b0 = rnd_band(); b1 = rnd_band(); b2 = rnd_band();
      @(negedge clk);
      n_cmp++;
      if (sample_valid_o !== exp_valid || ready_o !== exp_ready || overrun_o !== exp_over || sat_o !== exp_sat
          || sample_o !== exp_sample) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got v=%b rdy=%b ov=%b sat=%b s=%0d want v=%b rdy=%b ov=%b sat=%b s=%0d",
                 name, c, sample_valid_o, ready_o, overrun_o, sat_o, sample_o,
                 exp_valid, exp_ready, exp_over, exp_sat, exp_sample);
      end
    end
    @(posedge clk); #1;
    valid_in = 0;
  endtask

  task automatic test_back_to_back();
    test_stream("back_to_back", 1'b1, 42);
    n_cmp++;
    if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", overrun_o); end
  endtask

  task automatic test_random();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    test_stream("random", 1'b0, 400);
  endtask

  initial begin
    rst_n = 0; valid_in = 0; b0 = '0; b1 = '0; b2 = '0;
    for (int k = 0; k < 3; k++) sel_gain[k] = 3'd3;
    test_reset();
    test_unity();
    test_mixed();
    test_floor_sat();
    test_gain_change();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
